// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 register file constants and swap FSM encoding
package lc3_pkg;

  localparam int              LC3_DATA_W   = 16;
  localparam int              LC3_NUM_REGS = 8;
  localparam int              LC3_SP_IDX   = 6;
  localparam logic [15:0]     LC3_USP_INIT = 16'h7000;
  localparam logic [15:0]     LC3_SSP_INIT = 16'h3000;

  localparam logic [1:0]      SW_IDLE = 2'd0;
  localparam logic [1:0]      SW_SAVE = 2'd1;
  localparam logic [1:0]      SW_LOAD = 2'd2;

endpackage

// File: rtl/lc3_sp_bank.sv
// rtl/lc3_sp_bank.sv - banked USP/SSP storage and the privilege-change swap FSM
module lc3_sp_bank
  import lc3_pkg::*;
#(
  parameter int                DATA_W   = LC3_DATA_W,
  parameter logic [DATA_W-1:0] USP_INIT = LC3_USP_INIT,
  parameter logic [DATA_W-1:0] SSP_INIT = LC3_SSP_INIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sp_swap_req,
  input  logic              sp_to_super,
  input  logic              sp_wr_pending,
  input  logic [DATA_W-1:0] sp_cur,
  output logic              sp_swap_ack,
  output logic              sp_swap_busy,
  output logic              priv_super,
  output logic              sp_load_en,
  output logic [DATA_W-1:0] sp_load_data
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] saved_usp_q, saved_usp_d;
  logic [DATA_W-1:0] saved_ssp_q, saved_ssp_d;
  logic              priv_q, priv_d;
  logic              ack_q, ack_d;

  always_comb begin
    state_d      = state_q;
    saved_usp_d  = saved_usp_q;
    saved_ssp_d  = saved_ssp_q;
    priv_d       = priv_q;
    ack_d        = 1'b0;
    sp_load_en   = 1'b0;
    sp_load_data = sp_to_super ? saved_ssp_q : saved_usp_q;
    case (state_q)
      SW_IDLE: begin
        // ack_q blocks a held request from re-firing in the ack cycle
        if (sp_swap_req && !ack_q) begin
          if (sp_to_super == priv_q) begin
            ack_d = 1'b1;
          end else if (!sp_wr_pending) begin
            state_d = SW_SAVE;
          end
        end
      end
      SW_SAVE: begin
        if (priv_q) saved_ssp_d = sp_cur;
        else        saved_usp_d = sp_cur;
        state_d = SW_LOAD;
      end
      SW_LOAD: begin
        sp_load_en = 1'b1;
        priv_d     = sp_to_super;
        ack_d      = 1'b1;
        state_d    = SW_IDLE;
      end
      default: state_d = SW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SW_IDLE;
      saved_usp_q <= USP_INIT;
      saved_ssp_q <= SSP_INIT;
      priv_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_usp_q <= saved_usp_d;
      saved_ssp_q <= saved_ssp_d;
      priv_q      <= priv_d;
      ack_q       <= ack_d;
    end
  end

  assign sp_swap_ack  = ack_q;
  assign sp_swap_busy = (state_q != SW_IDLE);
  assign priv_super   = priv_q;

endmodule

// File: rtl/lc3_regfile_bank.sv
// rtl/lc3_regfile_bank.sv - LC-3 register file with banked stack pointer and busy scoreboard
module lc3_regfile_bank
  import lc3_pkg::*;
#(
  parameter int                DATA_W   = LC3_DATA_W,
  parameter int                NUM_REGS = LC3_NUM_REGS,
  parameter int                ADDR_W   = $clog2(NUM_REGS),
  parameter int                SP_IDX   = LC3_SP_IDX,
  parameter logic [DATA_W-1:0] USP_INIT = LC3_USP_INIT,
  parameter logic [DATA_W-1:0] SSP_INIT = LC3_SSP_INIT,
  parameter bit                BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_reg,
  input  logic [ADDR_W-1:0]   dr,
  input  logic [DATA_W-1:0]   bus,
  input  logic [ADDR_W-1:0]   sr1,
  input  logic [ADDR_W-1:0]   sr2,
  output logic [DATA_W-1:0]   sr1out,
  output logic [DATA_W-1:0]   sr2out,
  input  logic                sp_swap_req,
  input  logic                sp_to_super,
  output logic                sp_swap_ack,
  output logic                sp_swap_busy,
  output logic                priv_super,
  input  logic                claim_valid,
  input  logic [ADDR_W-1:0]   claim_reg,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                sr1_busy,
  output logic                sr2_busy
);

  localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_IDX);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                user_wr;
  logic                sp_load_en;
  logic [DATA_W-1:0]   sp_load_data;

  lc3_sp_bank #(
    .DATA_W   (DATA_W),
    .USP_INIT (USP_INIT),
    .SSP_INIT (SSP_INIT)
  ) u_sp_bank (
    .clk           (clk),
    .rst_n         (rst_n),
    .sp_swap_req   (sp_swap_req),
    .sp_to_super   (sp_to_super),
    .sp_wr_pending (ld_reg && (dr == SP_A)),
    .sp_cur        (regs_q[SP_A]),
    .sp_swap_ack   (sp_swap_ack),
    .sp_swap_busy  (sp_swap_busy),
    .priv_super    (priv_super),
    .sp_load_en    (sp_load_en),
    .sp_load_data  (sp_load_data)
  );

  // A write to SP while a swap is in flight is dropped, and so is not forwarded either
  assign user_wr = ld_reg && !(sp_swap_busy && (dr == SP_A));

  always_comb begin
    regs_d = regs_q;
    if (user_wr) regs_d[dr] = bus;
    if (sp_load_en) regs_d[SP_A] = sp_load_data;
  end

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (claim_valid && (claim_reg == ADDR_W'(i)))  busy_d[i] = 1'b1;
      else if (ld_reg && (dr == ADDR_W'(i)))         busy_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? USP_INIT : '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign sr1out   = (BYPASS && user_wr && (dr == sr1)) ? bus : regs_q[sr1];
  assign sr2out   = (BYPASS && user_wr && (dr == sr2)) ? bus : regs_q[sr2];
  assign busy_vec = busy_q;
  assign sr1_busy = busy_q[sr1];
  assign sr2_busy = busy_q[sr2];

endmodule
